ddr_input_conditioner: RTL and testbench

- Front-end stage between the raw board pushbuttons and the game/arrow-judging logic.
- Synchronises and debounces the four direction buttons (UP, DOWN, LEFT, RIGHT) and the three speed buttons (slow, normal, fast).
- Emits clean levels, single-cycle press pulses, and a registered scroll-speed selection for the game core.

---
 rtl/ddr_input_conditioner_pkg.sv | 25 ++
 rtl/ddr_input_conditioner_debounce_channel.sv | 50 +++++
 rtl/ddr_input_conditioner.sv | 70 +++++++
 tb/tb_ddr_input_conditioner.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_input_conditioner_pkg.sv
// Shared constants for the pushbutton front end and the game core:
// scroll-speed codes, direction bit positions and the speed-priority helper.
package ddr_input_conditioner_pkg;

  localparam logic [1:0] SPEED_SLOW   = 2'd0;
  localparam logic [1:0] SPEED_NORMAL = 2'd1;
  localparam logic [1:0] SPEED_FAST   = 2'd2;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  // Fast wins over normal, normal over slow; no press keeps the current speed.
  function automatic logic [1:0] speed_select(input logic slow_p,
                                              input logic normal_p,
                                              input logic fast_p,
                                              input logic [1:0] cur);
    if (fast_p)        return SPEED_FAST;
    else if (normal_p) return SPEED_NORMAL;
    else if (slow_p)   return SPEED_SLOW;
    else               return cur;
  endfunction

endpackage

// File: rtl/ddr_input_conditioner_debounce_channel.sv
// One pushbutton channel: two-flop synchroniser, run-length debouncer and
// rising-edge pulse on the debounced level.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_q <= stable;
      // Any sample agreeing with the stable state restarts the run.
      if (sync2 != stable) begin
        if (cnt == CNT_MAX) begin
          stable <= ~stable;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign level = stable;
  assign press = stable & ~stable_q;

endmodule

// File: rtl/ddr_input_conditioner.sv
// Board-button front end: seven debounced channels, direction level/press
// outputs and the registered scroll-speed selection.
module ddr_input_conditioner
  import ddr_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       UP,
  input  logic       DOWN,
  input  logic       LEFT,
  input  logic       RIGHT,
  input  logic       slow,
  input  logic       normal,
  input  logic       fast,
  output logic [3:0] dir_level,
  output logic [3:0] dir_press,
  output logic       any_press,
  output logic [1:0] speed,
  output logic       speed_change
);

  localparam int CH_SLOW   = 4;
  localparam int CH_NORMAL = 5;
  localparam int CH_FAST   = 6;

  logic [6:0] raw_all;
  logic [6:0] level_all;
  logic [6:0] press_all;
  logic [1:0] speed_next;
  logic       speed_level_unused;

  // Low four bits line up with the DIR_* indices; speed buttons sit above.
  assign raw_all = {fast, normal, slow, UP, DOWN, LEFT, RIGHT};

  for (genvar i = 0; i < 7; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_all[i]),
      .level(level_all[i]),
      .press(press_all[i])
    );
  end

  assign dir_level = level_all[3:0];
  assign dir_press = press_all[3:0];
  assign any_press = |press_all[3:0];

  assign speed_level_unused = ^level_all[6:4];

  assign speed_next = speed_select(press_all[CH_SLOW], press_all[CH_NORMAL],
                                   press_all[CH_FAST], speed);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      speed        <= SPEED_NORMAL;
      speed_change <= 1'b0;
    end else begin
      speed        <= speed_next;
      speed_change <= (speed_next != speed);
    end
  end

endmodule

// File: tb/tb_ddr_input_conditioner.sv
// Directed bench for ddr_input_conditioner with a sample-history model and
// literal expectations for each scenario.
module tb_ddr_input_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] raw;  // {fast, normal, slow, UP, DOWN, LEFT, RIGHT}
  logic [3:0] dir_level;
  logic [3:0] dir_press;
  logic       any_press;
  logic [1:0] speed;
  logic       speed_change;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  ddr_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .UP          (raw[3]),
    .DOWN        (raw[2]),
    .LEFT        (raw[1]),
    .RIGHT       (raw[0]),
    .slow        (raw[4]),
    .normal      (raw[5]),
    .fast        (raw[6]),
    .dir_level   (dir_level),
    .dir_press   (dir_press),
    .any_press   (any_press),
    .speed       (speed),
    .speed_change(speed_change)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A level flips once the last D synchronised samples all disagree with it;
  // the synchronised sample seen at an edge is the raw value from two edges
  // earlier (zero until two post-reset samples exist).
  logic [63:0] raw_h [7];
  logic [63:0] s_h   [7];
  int          n_edges;
  logic [6:0]  m_level, m_prev, mp;
  logic [1:0]  m_speed, ns;
  logic        m_change, s_w, all_w;

  initial begin
    m_level = '0; m_prev = '0; m_speed = 2'd1; m_change = 1'b0; n_edges = 0;
    for (int c = 0; c < 7; c++) begin raw_h[c] = '0; s_h[c] = '0; end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_level = '0; m_prev = '0; m_speed = 2'd1; m_change = 1'b0; n_edges = 0;
      for (int c = 0; c < 7; c++) begin raw_h[c] = '0; s_h[c] = '0; end
    end else begin
      mp = m_level & ~m_prev;
      if (mp[6])      ns = 2'd2;
      else if (mp[5]) ns = 2'd1;
      else if (mp[4]) ns = 2'd0;
      else            ns = m_speed;
      m_change = (ns != m_speed);
      m_speed  = ns;
      m_prev   = m_level;
      for (int c = 0; c < 7; c++) begin
        s_w      = (n_edges >= 2) ? raw_h[c][1] : 1'b0;
        raw_h[c] = {raw_h[c][62:0], raw[c]};
        s_h[c]   = {s_h[c][62:0], s_w};
      end
      n_edges++;
      for (int c = 0; c < 7; c++) begin
        all_w = 1'b1;
        for (int k = 0; k < D; k++) if (s_h[c][k] == m_level[c]) all_w = 1'b0;
        if (all_w && n_edges >= D + 2) m_level[c] = ~m_level[c];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    check("model_level", dir_level, m_level[3:0]);
    check("model_press", dir_press, (m_level[3:0] & ~m_prev[3:0]));
    check("model_any", any_press, |(m_level[3:0] & ~m_prev[3:0]));
    check("model_speed", speed, m_speed);
    check("model_change", speed_change, m_change);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle(input int n, output int dir_pulses, output int spd_pulses);
    dir_pulses = 0; spd_pulses = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (dir_press != 4'b0) dir_pulses++;
      if (speed_change) spd_pulses++;
    end
  endtask

  int   dp, sp, dp2, sp2, lvl_seen;
  logic [3:0] press_val;

  initial begin
    rst_n = 1'b0;
    raw   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: reset values
    check("rst_speed", speed, 8'd1);
    check("rst_level", dir_level, 8'd0);
    check("rst_press", dir_press, 8'd0);
    check("rst_change", speed_change, 8'd0);
    settle(4, dp, sp);

    // 2: UP held 20 cycles, single pulse between edges 5 and 6
    raw[3] = 1'b1;
    dp = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 4) check("up_level_e4", dir_level[3], 8'd0);
      if (i == 5) begin
        check("up_level_e5", dir_level[3], 8'd1);
        check("up_press_e5", dir_press, 8'b1000);
        check("up_any_e5", any_press, 8'd1);
      end
      if (i == 6) check("up_press_e6", dir_press, 8'd0);
      if (dir_press != 4'b0) dp++;
    end
    check("up_pulse_count", dp[7:0], 8'd1);
    raw[3] = 1'b0;
    settle(8, dp, sp);
    check("up_release_pulses", dp[7:0], 8'd0);
    check("up_release_level", dir_level, 8'd0);

    // 3: LEFT glitches never reach D samples
    lvl_seen = 0;
    raw[1] = 1'b1; step(); step();
    raw[1] = 1'b0; step();
    raw[1] = 1'b1; step(); step();
    raw[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (dir_level != 4'b0 || dir_press != 4'b0) lvl_seen++;
    end
    check("left_glitch", lvl_seen[7:0], 8'd0);

    // 4: fast, then normal+slow together, then normal again
    raw[6] = 1'b1;
    sp = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 6) begin
        check("fast_change_e6", speed_change, 8'd1);
        check("fast_speed_e6", speed, 8'd2);
      end
      if (speed_change) sp++;
    end
    raw[6] = 1'b0;
    settle(8, dp, sp2);
    check("fast_changes", 8'(sp + sp2), 8'd1);
    check("fast_speed", speed, 8'd2);

    raw[5] = 1'b1; raw[4] = 1'b1;
    settle(10, dp, sp);
    raw[5] = 1'b0; raw[4] = 1'b0;
    settle(8, dp, sp2);
    check("ns_changes", 8'(sp + sp2), 8'd1);
    check("ns_speed", speed, 8'd1);

    raw[5] = 1'b1;
    settle(10, dp, sp);
    raw[5] = 1'b0;
    settle(8, dp, sp2);
    check("same_speed_changes", 8'(sp + sp2), 8'd0);
    check("same_speed", speed, 8'd1);

    // 5: UP and RIGHT together
    raw[3] = 1'b1; raw[0] = 1'b1;
    dp = 0; press_val = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (dir_press != 4'b0) begin dp++; press_val = dir_press; end
    end
    check("dual_pulse_count", dp[7:0], 8'd1);
    check("dual_press_val", press_val, 8'b1001);
    raw[3] = 1'b0; raw[0] = 1'b0;
    settle(8, dp, sp);

    // 6: DOWN held through a reset that lands at count 2
    raw[2] = 1'b1;
    settle(4, dp, sp);
    check("down_pre_reset", dp[7:0], 8'd0);
    rst_n = 1'b0;
    #1;
    check("down_in_reset_speed", speed, 8'd1);
    step(); step();
    check("down_in_reset_level", dir_level, 8'd0);
    rst_n = 1'b1;
    dp = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 4) check("down_press_e4", dir_press, 8'd0);
      if (i == 5) check("down_press_e5", dir_press, 8'b0100);
      if (dir_press != 4'b0) dp++;
    end
    check("down_pulse_count", dp[7:0], 8'd1);
    raw[2] = 1'b0;
    settle(8, dp, sp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
